// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core sequencer: opcodes, slot encoding and
// the control-strobe bundle consumed by the PC, accumulator and bus blocks.
package risc_pkg;

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } slot_e;

  typedef struct packed {
    logic load_ir;
    logic rd;
    logic wr;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '0;

  // Operand-reading group: these all fetch a memory operand into the ALU.
  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

  function automatic slot_e next_slot(input slot_e s);
    return slot_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational slot/opcode decode into the control-strobe bundle.
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  slot_e      i_slot,
  input  logic [2:0] i_opcode,
  input  logic       i_zero,
  output ctl_t       o_ctl
);

  logic w_alu;
  logic w_sto;
  logic w_jmp;
  logic w_skip;

  assign w_alu  = is_alu(i_opcode);
  assign w_sto  = (i_opcode == OP_STO);
  assign w_jmp  = (i_opcode == OP_JMP);
  assign w_skip = (i_opcode == OP_SKZ) && i_zero;

  always_comb begin
    o_ctl = CTL_IDLE;
    case (i_slot)
      S0, S1: begin
        o_ctl.rd      = 1'b1;
        o_ctl.load_ir = 1'b1;
        o_ctl.inc_pc  = 1'b1;
      end
      S3: begin
        o_ctl.halt = (i_opcode == OP_HLT);
      end
      S4: begin
        o_ctl.rd          = w_alu;
        o_ctl.datactl_ena = w_sto;
        o_ctl.load_pc     = w_jmp;
      end
      S5: begin
        o_ctl.rd          = w_alu;
        o_ctl.load_acc    = w_alu;
        o_ctl.datactl_ena = w_sto;
        o_ctl.wr          = w_sto;
        o_ctl.load_pc     = w_jmp;
        o_ctl.inc_pc      = w_skip;
      end
      S6: begin
        o_ctl.rd          = w_alu;
        o_ctl.datactl_ena = w_sto;
        o_ctl.inc_pc      = w_skip;
      end
      default: o_ctl = CTL_IDLE;
    endcase
  end

endmodule

// File: rtl/risc_ctrl.sv
// Eight-slot instruction sequencer with registered control strobes.
// Build option RISC_HALT_STICKY_EN: HLT freezes the sequencer until reset.
module risc_ctrl
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic [2:0] slot
);

`ifdef RISC_HALT_STICKY_EN
  localparam bit HaltSticky = 1'b1;
`else
  localparam bit HaltSticky = 1'b0;
`endif

  slot_e r_slot;
  ctl_t  r_ctl;
  logic  r_halted;
  ctl_t  w_dec;

  risc_ctrl_decode u_decode (
    .i_slot   (r_slot),
    .i_opcode (opcode),
    .i_zero   (zero),
    .o_ctl    (w_dec)
  );

  // While halted, the edge that loaded halt already left r_ctl as halt-only,
  // so holding every register keeps halt high and all other strobes low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot   <= S0;
      r_ctl    <= CTL_IDLE;
      r_halted <= 1'b0;
    end else if (r_halted) begin
      r_slot   <= r_slot;
      r_ctl    <= r_ctl;
      r_halted <= 1'b1;
    end else if (!ena) begin
      r_slot <= S0;
      r_ctl  <= CTL_IDLE;
    end else begin
      r_slot   <= next_slot(r_slot);
      r_ctl    <= w_dec;
      r_halted <= HaltSticky && w_dec.halt;
    end
  end

  assign load_ir     = r_ctl.load_ir;
  assign rd          = r_ctl.rd;
  assign wr          = r_ctl.wr;
  assign inc_pc      = r_ctl.inc_pc;
  assign load_pc     = r_ctl.load_pc;
  assign load_acc    = r_ctl.load_acc;
  assign datactl_ena = r_ctl.datactl_ena;
  assign halt        = r_ctl.halt;
  assign slot        = r_slot;

endmodule
